fp_absolute: RTL and testbench
==============================

// Module: fp_absolute
// PURPOSE
//   Floating-point absolute value for the fpWrapper operator set.
//   Clears the sign bit of an IEEE-754 binary32 operand.
//   The output is registered to match the pipeline timing of the
//   sibling fp operators.
//   Bit-exact IEEE-754 abs(): no rounding, no exceptions, no NaN canonicalisation.
// PARAMETERS
//   FP_WIDTH  32  total operand width (sign + exponent + mantissa)
//   LATENCY   1   pipeline register stages from value to result; range 0..8
//                 (0 = purely combinational)
// PORTS
//   aclk    input   1         single clock; all state updates on its rising edge
//   reset   input   1         synchronous, active-high reset
//   value   input   FP_WIDTH  operand, IEEE-754 binary32 bit pattern
//   result  output  FP_WIDTH  |value|, IEEE-754 bit pattern
// BEHAVIOUR
//   - Function: result = {1'b0, value[FP_WIDTH-2:0]}.
//     - The sign bit (MSB) is forced to 0.
//     - Exponent and mantissa pass through unchanged.
//   - All encodings are handled identically:
//     - +0 and -0 both map to +0 (32'h00000000).
//     - -Inf maps to +Inf (32'h7f800000).
//     - NaN: sign cleared, payload preserved; qNaN/sNaN kept as-is, no quieting.
//     - Subnormals pass through (no flush-to-zero).
//   - No exception flags; no overflow is possible.
//   - Latency is exactly LATENCY rising edges of aclk.
//     - LATENCY=1: value sampled at edge N appears on result right after edge N.
//   - No handshake: a new operand is accepted every cycle (initiation interval 1).
//     The result stream is the input stream delayed by LATENCY.
//   - Reset:
//     - While reset=1 at a rising edge, every pipeline stage loads 0.
//     - Hence result = 32'h00000000 after the first reset edge.
//     - Reset asserted mid-stream discards all in-flight operands.
//     - After reset deasserts, result shows 0 until the first post-reset
//       operand arrives, i.e. for LATENCY cycles.
//   - LATENCY=0: result is combinational from value; reset has no effect.
//   - X/undriven value propagates to result; no X-masking. Before the first
//     reset or operand, result is unspecified in simulation.
// STRUCTURE
//   - Shared package fp_pkg:
//     - FP32_WIDTH=32, FP32_EXP_W=8, FP32_MAN_W=23, FP32_SIGN_BIT=31
//     - typedef fp32_t: packed struct {sign, exp[7:0], man[22:0]}
//     - constants FP32_POS_ZERO, FP32_POS_INF
//   - One sub-module fp_pipe_reg #(WIDTH, DEPTH), shared with other fp
//     operators: a DEPTH-stage register chain with sync active-high reset.
//     DEPTH=0 degenerates to a wire.
//   - The top computes the sign-cleared word combinationally and feeds it
//     through fp_pipe_reg with DEPTH=LATENCY.
// TESTING (100 MHz aclk, LATENCY=1; check result one edge after drive)
//   1. value=32'h40f8a3d7 (+7.77) -> result=32'h40f8a3d7
//   2. value=32'hc0f8a3d7 (-7.77) -> result=32'h40f8a3d7
//   3. value=32'h00000000 (+0) -> 32'h00000000;
//      value=32'h80000000 (-0) -> 32'h00000000
//   4. Specials:
//      - 32'hff800000 -> 32'h7f800000
//      - 32'hffc00001 -> 32'h7fc00001
//      - 32'h80000001 -> 32'h00000001
//   5. Back-to-back stream of 4 operands on consecutive edges
//      -> results on consecutive edges, in order, each delayed by 1 cycle.
//   6. Assert reset for 1 cycle mid-stream:
//      - result=32'h00000000 on the edge after reset.
//      - The next operand's abs appears 1 edge after it is driven.
//      - Repeat scenarios 1-2 with LATENCY=0 and LATENCY=3: check the delay.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 field widths, record type and constant encodings
package fp_pkg;
  localparam int FP32_WIDTH = 32;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_SIGN_BIT = 31;
  typedef struct packed {
    logic sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;
  localparam fp32_t FP32_POS_ZERO = '{sign: 1'b0, exp: '0, man: '0};
  localparam fp32_t FP32_POS_INF = '{sign: 1'b0, exp: '1, man: '0};
endpackage

// File: rtl/fp_pipe_reg.sv
// fp_pipe_reg: DEPTH-stage register chain with sync active-high reset, wire when DEPTH is 0
module fp_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] s [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) s <= '{default: '0};
      else begin
        s[0] <= d;
        for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
      end
    end
    assign q = s[DEPTH-1];
  end
endmodule

// File: rtl/fp_absolute.sv
// fp_absolute: IEEE-754 abs by clearing the sign bit, delayed by LATENCY register stages
module fp_absolute
  import fp_pkg::*;
#(
  parameter int FP_WIDTH = FP32_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic [FP_WIDTH-1:0] value,
  output logic [FP_WIDTH-1:0] result
);
  logic [FP_WIDTH-1:0] abs_w;
  assign abs_w = {1'b0, value[FP_WIDTH-2:0]};
  fp_pipe_reg #(.WIDTH(FP_WIDTH), .DEPTH(LATENCY)) u_pipe (
    .clk(aclk),
    .rst(reset),
    .d(abs_w),
    .q(result)
  );
endmodule

// File: tb/tb_fp_absolute.sv
// tb_fp_absolute: directed vectors on LATENCY 0, 1 and 3 instances sharing one operand stream
module tb_fp_absolute;
  logic aclk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] value = '0;
  logic [31:0] r0, r1, r3;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] vin [8] = '{32'h40f8a3d7, 32'hc0f8a3d7, 32'h00000000, 32'h80000000,
                           32'hff800000, 32'hffc00001, 32'h80000001, 32'h7fffffff};
  logic [31:0] vexp [8] = '{32'h40f8a3d7, 32'h40f8a3d7, 32'h00000000, 32'h00000000,
                            32'h7f800000, 32'h7fc00001, 32'h00000001, 32'h7fffffff};
  always #5 aclk = ~aclk;
  fp_absolute #(.FP_WIDTH(32), .LATENCY(0)) u_l0 (.aclk(aclk), .reset(reset), .value(value), .result(r0));
  fp_absolute #(.FP_WIDTH(32), .LATENCY(1)) u_l1 (.aclk(aclk), .reset(reset), .value(value), .result(r1));
  fp_absolute #(.FP_WIDTH(32), .LATENCY(3)) u_l3 (.aclk(aclk), .reset(reset), .value(value), .result(r3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_l1", r1, 32'h0);
    chk("rst_l3", r3, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      value = vin[i];
      #1;
      chk($sformatf("l0_v%0d", i), r0, vexp[i]);
      step();
      chk($sformatf("l1_v%0d", i), r1, vexp[i]);
      chk($sformatf("l3_v%0d", i), r3, i >= 2 ? vexp[i-2] : 32'h0);
    end
    value = 32'hc0f8a3d7;
    reset = 1'b1;
    step();
    chk("mid_rst_l1", r1, 32'h0);
    chk("mid_rst_l3", r3, 32'h0);
    reset = 1'b0;
    value = 32'hff800000;
    step();
    chk("post_rst_l1_a", r1, 32'h7f800000);
    chk("post_rst_l3_a", r3, 32'h0);
    value = 32'h80000001;
    step();
    chk("post_rst_l1_b", r1, 32'h00000001);
    chk("post_rst_l3_b", r3, 32'h0);
    value = 32'h00000000;
    step();
    chk("post_rst_l1_c", r1, 32'h00000000);
    chk("post_rst_l3_c", r3, 32'h7f800000);
    step();
    chk("post_rst_l3_d", r3, 32'h00000001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
